// File: rtl/pe_inst_sequencer.sv
// Command-level sequencer for one processing element: expands a dot-product command into
// the PE instruction stream, drives aligned operand-SRAM reads and flags the result cycle.
package pe_inst_pkg;
   typedef logic [1:0] mode_t;
   typedef logic [7:0] value_t;

   typedef struct packed {
      logic [3:0] opcode;
      value_t     value;
      mode_t      mode;
   } pe_inst_t;

   localparam mode_t      MODE_INT8     = 2'd0;
   localparam mode_t      MODE_INT16    = 2'd1;
   localparam mode_t      MODE_INT32    = 2'd2;
   localparam logic [3:0] PE_RND_OPCODE = 4'd1;
   localparam value_t     PE_CLR_VALUE  = 8'd1;
   localparam value_t     PE_PASS_VALUE = 8'd2;
   localparam value_t     PE_MAC_VALUE  = 8'd3;
   localparam value_t     PE_OUT_VALUE  = 8'd4;
endpackage

module pe_inst_sequencer
   import pe_inst_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  mode_t             cmd_mode,
   input  logic [LEN_W-1:0]  cmd_len,
   input  value_t            cmd_shift,
   input  logic              cmd_pass,
   input  logic [ADDR_W-1:0] cmd_bias_addr,
   input  logic [ADDR_W-1:0] cmd_vec_base,
   input  logic [ADDR_W-1:0] cmd_mat_base,
   input  logic              stall,
   output pe_inst_t          pe_inst,
   output logic              pe_inst_valid,
   output logic              rd_en,
   output logic [ADDR_W-1:0] vec_rd_addr,
   output logic [ADDR_W-1:0] mat_rd_addr,
   output logic              out_valid
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_MAC    = 3'd2,
      S_RND    = 3'd3,
      S_OUT    = 3'd4,
      S_DRAIN1 = 3'd5,
      S_DRAIN2 = 3'd6
   } state_t;

   // state_r names the phase whose instruction was issued last; a stall simply holds it.
   state_t            state_r, state_s;
   mode_t             mode_r, mode_s;
   value_t            shift_r, shift_s;
   logic [LEN_W-1:0]  rem_r, rem_s;
   logic [ADDR_W-1:0] vec_cnt_r, vec_cnt_s, mat_cnt_r, mat_cnt_s;
   logic [ADDR_W-1:0] vec_addr_r, vec_addr_s, mat_addr_r, mat_addr_s;
   pe_inst_t          inst_r, inst_s;
   logic              inst_valid_r, inst_valid_s;
   logic              rd_en_r, rd_en_s;
   logic              out_valid_r, out_valid_s;
   logic              issue_s;

   assign cmd_ready     = (state_r == S_IDLE);
   assign pe_inst       = inst_r;
   assign pe_inst_valid = inst_valid_r;
   assign rd_en         = rd_en_r;
   assign vec_rd_addr   = vec_addr_r;
   assign mat_rd_addr   = mat_addr_r;
   assign out_valid     = out_valid_r;

   // Next phase selection, then the registered instruction for the phase being entered.
   always_comb begin
      state_s      = state_r;
      mode_s       = mode_r;
      shift_s      = shift_r;
      rem_s        = rem_r;
      vec_cnt_s    = vec_cnt_r;
      mat_cnt_s    = mat_cnt_r;
      vec_addr_s   = vec_addr_r;
      mat_addr_s   = mat_addr_r;
      inst_s       = '0;
      inst_valid_s = 1'b0;
      rd_en_s      = 1'b0;
      out_valid_s  = 1'b0;
      issue_s      = 1'b0;

      case (state_r)
         S_IDLE: begin
            if (cmd_valid) begin
               state_s   = S_INIT;
               mode_s    = cmd_mode;
               shift_s   = cmd_shift;
               rem_s     = cmd_len;
               vec_cnt_s = cmd_vec_base;
               mat_cnt_s = cmd_mat_base;
               issue_s   = 1'b1;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_INIT, S_MAC: begin
            if (stall) begin
               state_s = state_r;
            end else if (rem_r != LEN_W'(0)) begin
               state_s = S_MAC;
               issue_s = 1'b1;
            end else if (shift_r != 8'd0) begin
               state_s = S_RND;
               issue_s = 1'b1;
            end else begin
               state_s = S_OUT;
               issue_s = 1'b1;
            end
         end
         S_RND: begin
            if (stall) begin
               state_s = state_r;
            end else begin
               state_s = S_OUT;
               issue_s = 1'b1;
            end
         end
         S_OUT: begin
            if (stall) begin
               state_s = state_r;
            end else begin
               state_s = S_DRAIN1;
            end
         end
         S_DRAIN1: begin
            state_s     = S_DRAIN2;
            out_valid_s = 1'b1;
         end
         S_DRAIN2: state_s = S_IDLE;
         default:  state_s = S_IDLE;
      endcase

      if (issue_s) begin
         case (state_s)
            S_INIT: begin
               inst_s       = {4'd0, (cmd_pass ? PE_PASS_VALUE : PE_CLR_VALUE), cmd_mode};
               inst_valid_s = 1'b1;
               rd_en_s      = cmd_pass;
               if (cmd_pass) begin
                  vec_addr_s = cmd_bias_addr;
               end else begin
                  vec_addr_s = vec_addr_r;
               end
            end
            S_MAC: begin
               inst_s       = {4'd0, PE_MAC_VALUE, mode_r};
               inst_valid_s = 1'b1;
               rd_en_s      = 1'b1;
               vec_addr_s   = vec_cnt_r;
               mat_addr_s   = mat_cnt_r;
               vec_cnt_s    = vec_cnt_r + ADDR_W'(1);
               mat_cnt_s    = mat_cnt_r + ADDR_W'(1);
               rem_s        = rem_r - LEN_W'(1);
            end
            S_RND: begin
               inst_s       = {PE_RND_OPCODE, shift_r, mode_r};
               inst_valid_s = 1'b1;
            end
            S_OUT: begin
               inst_s       = {4'd0, PE_OUT_VALUE, mode_r};
               inst_valid_s = 1'b1;
            end
            default: inst_valid_s = 1'b0;
         endcase
      end else begin
         inst_valid_s = 1'b0;
      end
   end

   // State, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= S_IDLE;
         mode_r       <= '0;
         shift_r      <= '0;
         rem_r        <= '0;
         vec_cnt_r    <= '0;
         mat_cnt_r    <= '0;
         vec_addr_r   <= '0;
         mat_addr_r   <= '0;
         inst_r       <= '0;
         inst_valid_r <= 1'b0;
         rd_en_r      <= 1'b0;
         out_valid_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         mode_r       <= mode_s;
         shift_r      <= shift_s;
         rem_r        <= rem_s;
         vec_cnt_r    <= vec_cnt_s;
         mat_cnt_r    <= mat_cnt_s;
         vec_addr_r   <= vec_addr_s;
         mat_addr_r   <= mat_addr_s;
         inst_r       <= inst_s;
         inst_valid_r <= inst_valid_s;
         rd_en_r      <= rd_en_s;
         out_valid_r  <= out_valid_s;
      end
   end

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Bench for pe_inst_sequencer: directed table, randomized commands with stalls and busy-time
// noise, a mid-burst reset, and a small SRAM + PE model that checks the final result value.
module tb_pe_inst_sequencer;
   import pe_inst_pkg::*;

   localparam int AW = 10;
   localparam int LW = 10;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   mode_t          cmd_mode = '0;
   logic [LW-1:0]  cmd_len = '0;
   value_t         cmd_shift = '0;
   logic           cmd_pass = 1'b0;
   logic [AW-1:0]  cmd_bias_addr = '0, cmd_vec_base = '0, cmd_mat_base = '0;
   logic           stall = 1'b0;
   pe_inst_t       pe_inst;
   logic           pe_inst_valid, rd_en, out_valid;
   logic [AW-1:0]  vec_rd_addr, mat_rd_addr;

   pe_inst_sequencer #(.ADDR_W(AW), .LEN_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_len(cmd_len), .cmd_shift(cmd_shift), .cmd_pass(cmd_pass),
      .cmd_bias_addr(cmd_bias_addr), .cmd_vec_base(cmd_vec_base), .cmd_mat_base(cmd_mat_base),
      .stall(stall), .pe_inst(pe_inst), .pe_inst_valid(pe_inst_valid), .rd_en(rd_en),
      .vec_rd_addr(vec_rd_addr), .mat_rd_addr(mat_rd_addr), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      mode_t         mode;
      logic [LW-1:0] len;
      value_t        shift;
      logic          pass;
      logic [AW-1:0] bias, vec, mat;
   } cmd_t;

   typedef struct packed {
      pe_inst_t      inst;
      logic          valid, rd;
      logic [AW-1:0] va, ma;
      logic          ov, ready;
   } exp_t;

   typedef struct packed {
      pe_inst_t      inst;
      logic          rd, vld, mld;
      logic [AW-1:0] va, ma;
   } item_t;

   typedef struct packed {
      cmd_t         c;
      logic [127:0] smask;
      int           exp_ov;
   } vec_t;

   int            checks = 0;
   int            errors = 0;
   logic [AW-1:0] hv = '0, hm = '0;

   // Operand SRAM contents as pure functions of the address.
   function automatic longint vmem(input logic [AW-1:0] a);
      return longint'(((int'(a) * 7 + 3) % 61) - 30);
   endfunction
   function automatic longint mmem(input logic [AW-1:0] a);
      return longint'(((int'(a) * 5 + 11) % 53) - 26);
   endfunction

   // One-cycle SRAM read plus a PE that executes each instruction one cycle after issue.
   longint   vdat = 0, mdat = 0, acc = 0, vout = 0;
   pe_inst_t iq = '0;
   logic     iqv = 1'b0;
   always @(posedge clk) begin
      vdat <= rd_en ? vmem(vec_rd_addr) : 64'sd0;
      mdat <= rd_en ? mmem(mat_rd_addr) : 64'sd0;
      iq   <= pe_inst;
      iqv  <= pe_inst_valid;
      if (iqv) begin
         if (iq.opcode == PE_RND_OPCODE)
            acc <= (acc + (64'sd1 <<< (int'(iq.value) - 1))) >>> int'(iq.value);
         else if (iq.value == PE_CLR_VALUE) acc <= 64'sd0;
         else if (iq.value == PE_PASS_VALUE) acc <= vdat;
         else if (iq.value == PE_MAC_VALUE) acc <= acc + vdat * mdat;
         else if (iq.value == PE_OUT_VALUE) vout <= acc;
      end
   end

   function automatic longint exp_result(input cmd_t c);
      longint s = c.pass ? vmem(c.bias) : 64'sd0;
      for (int i = 0; i < int'(c.len); i++)
         s += vmem(c.vec + AW'(i)) * mmem(c.mat + AW'(i));
      if (c.shift != 8'd0)
         s = (s + (64'sd1 <<< (int'(c.shift) - 1))) >>> int'(c.shift);
      return s;
   endfunction

   task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic exp_t observe();
      return {pe_inst, pe_inst_valid, rd_en, vec_rd_addr, mat_rd_addr, out_valid, cmd_ready};
   endfunction

   // Issue one command at cycle 0 and compare every following cycle against the model timeline.
   task automatic run_cmd(input cmd_t c, input logic [127:0] smask, input int exp_ov, input bit noise);
      item_t items[$];
      exp_t  tl[$];
      exp_t  e;
      item_t it;
      int    idx, n, ov_dut;
      it = {{4'd0, (c.pass ? PE_PASS_VALUE : PE_CLR_VALUE), c.mode}, c.pass, c.pass, 1'b0, c.bias, 10'd0};
      items.push_back(it);
      for (int i = 0; i < int'(c.len); i++) begin
         it = {{4'd0, PE_MAC_VALUE, c.mode}, 1'b1, 1'b1, 1'b1, c.vec + AW'(i), c.mat + AW'(i)};
         items.push_back(it);
      end
      if (c.shift != 8'd0) begin
         it = {{PE_RND_OPCODE, c.shift, c.mode}, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
         items.push_back(it);
      end
      it = {{4'd0, PE_OUT_VALUE, c.mode}, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
      items.push_back(it);
      n = items.size();
      idx = 0;
      for (int k = 1; k < 400; k++) begin
         e = '0;
         if (k > 1 && idx <= n && k - 1 < 128 && smask[k-1]) begin
            e.valid = 1'b0;
         end else if (idx < n) begin
            e.inst  = items[idx].inst;
            e.valid = 1'b1;
            e.rd    = items[idx].rd;
            if (items[idx].vld) hv = items[idx].va;
            if (items[idx].mld) hm = items[idx].ma;
            idx++;
         end else if (idx == n) begin
            idx++;
         end else if (idx == n + 1) begin
            e.ov = 1'b1;
            idx++;
         end else begin
            e.ready = 1'b1;
         end
         e.va = hv;
         e.ma = hm;
         tl.push_back(e);
         if (e.ready) break;
      end

      @(posedge clk); #1;
      cmd_mode = c.mode; cmd_len = c.len; cmd_shift = c.shift; cmd_pass = c.pass;
      cmd_bias_addr = c.bias; cmd_vec_base = c.vec; cmd_mat_base = c.mat;
      cmd_valid = 1'b1; stall = 1'b0;
      @(negedge clk);
      chk("ready_before_accept", 0, 64'(cmd_ready), 64'd1);
      ov_dut = -1;
      for (int k = 1; k <= tl.size(); k++) begin
         @(posedge clk); #1;
         stall = (k < 128) ? smask[k] : 1'b0;
         if (k == tl.size()) begin
            cmd_valid = 1'b0;
            stall = 1'b0;
         end else if (noise) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_len = LW'($urandom_range(0, 5));
            cmd_pass = 1'($urandom_range(0, 1));
            cmd_vec_base = AW'($urandom);
            cmd_bias_addr = AW'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
         chk("outputs", k, 64'(observe()), 64'(tl[k-1]));
         if (out_valid && ov_dut < 0) begin
            ov_dut = k;
            chk("pe_result", k, 64'(vout), 64'(exp_result(c)));
         end
      end
      if (exp_ov >= 0) chk("out_valid_cycle", ov_dut, 64'(ov_dut), 64'(exp_ov));
   endtask

   vec_t tbl[7];
   cmd_t rc;
   logic [127:0] rmask;
   bit seen_ov;

   initial begin
      tbl[0] = '{'{MODE_INT8,  10'd4, 8'd0, 1'b0, 10'h000, 10'h010, 10'h020}, 128'd0, 8};
      tbl[1] = '{'{MODE_INT16, 10'd3, 8'd5, 1'b1, 10'h3FF, 10'h100, 10'h200}, 128'd0, 8};
      tbl[2] = '{'{MODE_INT8,  10'd0, 8'd0, 1'b0, 10'h000, 10'h040, 10'h050}, 128'd0, 4};
      tbl[3] = '{'{MODE_INT32, 10'd4, 8'd0, 1'b0, 10'h000, 10'h060, 10'h070}, 128'd1 << 3, 9};
      tbl[4] = '{'{MODE_INT8,  10'd4, 8'd0, 1'b0, 10'h000, 10'h3FE, 10'h3FD}, 128'd0, 8};
      tbl[5] = '{'{MODE_INT16, 10'd0, 8'd3, 1'b1, 10'h005, 10'h000, 10'h000}, 128'd0, 5};
      tbl[6] = '{'{MODE_INT32, 10'd2, 8'd0, 1'b0, 10'h000, 10'h123, 10'h234},
                 (128'd1 << 1) | (128'd1 << 4) | (128'd1 << 7), 8};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_state", 0, 64'(observe()), 64'(exp_t'({14'd0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1})));

      for (int i = 0; i < 7; i++) run_cmd(tbl[i].c, tbl[i].smask, tbl[i].exp_ov, 1'b0);

      // Reset pulsed in the middle of a MAC burst.
      @(posedge clk); #1;
      cmd_mode = MODE_INT8; cmd_len = 10'd8; cmd_shift = 8'd0; cmd_pass = 1'b0;
      cmd_vec_base = 10'h080; cmd_mat_base = 10'h090; cmd_valid = 1'b1;
      @(posedge clk); #1 cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_mid_burst", 5, 64'(observe()), 64'(exp_t'({14'd0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1})));
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("after_release", 6, 64'(observe()), 64'(exp_t'({14'd0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1})));
      hv = '0;
      hm = '0;
      seen_ov = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen_ov = 1'b1;
      end
      chk("no_ov_after_reset", 0, 64'(seen_ov), 64'd0);
      run_cmd(tbl[0].c, 128'd0, 8, 1'b0);

      for (int r = 0; r < 40; r++) begin
         rc.mode  = mode_t'($urandom_range(0, 2));
         rc.len   = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(13, 40)) : LW'($urandom_range(0, 12));
         rc.shift = ($urandom_range(0, 3) == 0) ? 8'd0 : value_t'($urandom_range(1, 15));
         rc.pass  = 1'($urandom_range(0, 1));
         rc.bias  = AW'($urandom);
         rc.vec   = AW'($urandom);
         rc.mat   = AW'($urandom);
         rmask    = '0;
         for (int b = 1; b < 128; b++) rmask[b] = ($urandom_range(0, 99) < 15);
         run_cmd(rc, rmask, -1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
